alu_uart_ctrl: RTL

Frame sequencer between the UART receiver/transmitter pair and the 8-bit ALU on the board. It collects a 3-byte command frame from the RX strobe stream: operand A, operand B, then opcode. It drives the ALU operand and opcode registers, captures the combinational ALU result, and hands it to the UART TX with a start/done handshake. It replaces the button-driven operand loading for the serial build of the ALU top level.

---
 rtl/alu_uart_ctrl_if.sv | 34 +++
 rtl/alu_uart_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_uart_ctrl_if.sv
// Bus between the ALU/UART frame sequencer and its surroundings.
// Groups the UART RX/TX handshake, the ALU operand/opcode/result lines
// and the status pulses.
//   slave  : the sequencer (consumes i_* signals, drives o_* signals)
//   master : the environment (UART pair + ALU, or a testbench)
interface alu_uart_ctrl_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_timeout;
    logic               o_overrun;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start,
               o_busy, o_timeout, o_overrun
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start,
               o_busy, o_timeout, o_overrun
    );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Frame sequencer between UART RX/TX and the 8-bit ALU.
// Collects a 3-byte frame (A, B, opcode), drives the ALU operand/opcode
// registers, captures the ALU result one cycle later and starts the TX.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous reset, active-low
//   bus     : alu_uart_ctrl_if.slave (RX byte/strobe, TX done, ALU result in;
//             operands, opcode, TX byte/start, busy/timeout/overrun out)
module alu_uart_ctrl #(
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned NB_OP       = 6,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input logic             i_clk,
    input logic             i_reset,
    alu_uart_ctrl_if.slave  bus
);
    localparam int unsigned NB_CNT = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST =
        (TIMEOUT_CYC > 0) ? NB_CNT'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_GET_OP,
        ST_COMPUTE,
        ST_WAIT_TX
    } state_t;

    state_t             state_q, state_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic [NB_DATA-1:0] data_a_q, data_a_d;
    logic [NB_DATA-1:0] data_b_q, data_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic               expired;

    // Inter-byte timer reached its last cycle (never true when disabled)
    assign expired = (TIMEOUT_CYC > 0) && (cnt_q == CNT_LAST);

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;

        case (state_q)
            ST_GET_A: begin
                cnt_d = '0;
                if (bus.i_rx_done) begin
                    data_a_d = bus.i_rx_data;
                    state_d  = ST_GET_B;
                end
            end
            ST_GET_B: begin
                // A byte arriving in the expiry cycle takes priority
                if (bus.i_rx_done) begin
                    data_b_d = bus.i_rx_data;
                    cnt_d    = '0;
                    state_d  = ST_GET_OP;
                end else if (expired) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_GET_A;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + NB_CNT'(1);
                end
            end
            ST_GET_OP: begin
                if (bus.i_rx_done) begin
                    op_d    = bus.i_rx_data[NB_OP-1:0];
                    cnt_d   = '0;
                    state_d = ST_COMPUTE;
                end else if (expired) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_GET_A;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + NB_CNT'(1);
                end
            end
            ST_COMPUTE: begin
                // Operands were stable for a full cycle; latch the ALU output
                tx_data_d  = bus.i_alu_result;
                tx_start_d = 1'b1;
                overrun_d  = bus.i_rx_done;
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                overrun_d = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    state_d = ST_GET_A;
                end
            end
            default: begin
                state_d = ST_GET_A;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_COMPUTE) || (state_d == ST_WAIT_TX);
    end

    // State, timer and output registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= ST_GET_A;
            cnt_q      <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.o_data_a   = data_a_q;
    assign bus.o_data_b   = data_b_q;
    assign bus.o_op       = op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.o_overrun  = overrun_q;

endmodule
